// File: rtl/ahb_master_arbiter.sv
// N-channel AHB master arbiter/mux with external-master handover.
// Address-phase owner and data-phase owner are tracked separately.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int RR_MODE     = 1,
    parameter int EXT_EN      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_bus_req,
    output logic [NUM_MASTERS-1:0]        m_bus_ack,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
    input  logic [NUM_MASTERS-1:0]        m_hwrite,
    input  logic [NUM_MASTERS*3-1:0]      m_hsize,
    input  logic [NUM_MASTERS*3-1:0]      m_hburst,
    input  logic [NUM_MASTERS*4-1:0]      m_hprot,
    input  logic [NUM_MASTERS*2-1:0]      m_htrans,
    input  logic [NUM_MASTERS-1:0]        m_hmastlock,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
    output logic [NUM_MASTERS-1:0]        m_hready,
    output logic [NUM_MASTERS-1:0]        m_hresp,
    output logic [DATA_W-1:0]             m_hrdata,
    input  logic                          ext_bus_req,
    output logic                          ext_bus_ack,
    output logic [ADDR_W-1:0]             haddr,
    output logic                          hwrite,
    output logic [2:0]                    hsize,
    output logic [2:0]                    hburst,
    output logic [3:0]                    hprot,
    output logic [1:0]                    htrans,
    output logic                          hmastlock,
    output logic [DATA_W-1:0]             hwdata,
    input  logic                          hready,
    input  logic                          hresp,
    input  logic [DATA_W-1:0]             hrdata,
    output logic [3:0]                    owner
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EXT,
        DRAIN
    } state_e;

    localparam logic [3:0] OWN_EXT  = 4'hE;
    localparam logic [3:0] OWN_NONE = 4'hF;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic                   ext_ack_q, ext_ack_d;
    logic [3:0]             owner_q, owner_d;
    logic [3:0]             rr_ptr_q, rr_ptr_d;
    logic [3:0]             dp_owner_q;
    logic                   dp_valid_q;

    logic [3:0] win;
    logic       win_vld;
    logic       owner_req;

    function automatic logic [3:0] wrap_idx(
        input logic [3:0] base,
        input int         k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return 4'(s);
    endfunction

    // Candidate search order starts at rr_ptr and wraps around.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!win_vld && m_bus_req[i] &&
                        wrap_idx(rr_ptr_q, k) == 4'(i)) begin
                        win     = 4'(i);
                        win_vld = 1'b1;
                    end
                end
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!win_vld && m_bus_req[i]) begin
                    win     = 4'(i);
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == 4'(i)) owner_req = m_bus_req[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        ext_ack_d = ext_ack_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (EXT_EN != 0 && ext_bus_req) begin
                    state_d   = EXT;
                    ext_ack_d = 1'b1;
                    owner_d   = OWN_EXT;
                end else if (win_vld) begin
                    state_d = GRANT;
                    owner_d = win;
                    ack_d   = '0;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (win == 4'(i)) ack_d[i] = 1'b1;
                    end
                    if (RR_MODE != 0) rr_ptr_d = wrap_idx(win, 1);
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    ack_d   = '0;
                    owner_d = OWN_NONE;
                    if (dp_valid_q && !hready) state_d = DRAIN;
                    else                       state_d = IDLE;
                end
            end
            EXT: begin
                if (!ext_bus_req) begin
                    ext_ack_d = 1'b0;
                    owner_d   = OWN_NONE;
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                if (hready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            ext_ack_q <= 1'b0;
            owner_q   <= OWN_NONE;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            ext_ack_q <= ext_ack_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Data phase follows the address phase only when the bus advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_owner_q <= OWN_NONE;
            dp_valid_q <= 1'b0;
        end else if (hready) begin
            dp_owner_q <= owner_q;
            dp_valid_q <= htrans[1];
        end
    end

    always_comb begin
        haddr     = '0;
        hwrite    = 1'b0;
        hsize     = 3'b011;
        hburst    = 3'b000;
        hprot     = 4'b0011;
        htrans    = 2'b00;
        hmastlock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == 4'(i)) begin
                haddr     = m_haddr[i*ADDR_W +: ADDR_W];
                hwrite    = m_hwrite[i];
                hsize     = m_hsize[i*3 +: 3];
                hburst    = m_hburst[i*3 +: 3];
                hprot     = m_hprot[i*4 +: 4];
                htrans    = m_htrans[i*2 +: 2];
                hmastlock = m_hmastlock[i];
            end
        end
    end

    always_comb begin
        hwdata   = '0;
        m_hready = '0;
        m_hresp  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (dp_owner_q == 4'(i)) begin
                m_hready[i] = hready;
                m_hresp[i]  = hresp;
                if (dp_valid_q) hwdata = m_hwdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign m_hrdata    = hrdata;
    assign m_bus_ack   = ack_q;
    assign ext_bus_ack = ext_ack_q;
    assign owner       = owner_q;

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Parametrised N-channel AHB master arbiter and multiplexer for the BIU.
- Successor to the fixed two-master TLB/L1 bus mux; it also arbitrates an external bus master.
- Grants the single AHB port to one internal master at a time, using round-robin or fixed priority.
- Address-phase and data-phase routing are tracked separately, so a grant handover never corrupts an in-flight data phase.

Parameters:
- NUM_MASTERS, 4: number of internal master channels (2..8).
- ADDR_W, 64: haddr width.
- DATA_W, 64: hwdata/hrdata width.
- RR_MODE, 1: 1 = round-robin among internal masters; 0 = fixed priority, lowest index wins.
- EXT_EN, 1: 1 = external master request honoured; 0 = ext_bus_req ignored and ext_bus_ack held at 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- m_bus_req  in  NUM_MASTERS  per-master bus request.
- m_bus_ack  out  NUM_MASTERS  per-master grant, registered, one-hot or zero.
- m_haddr  in  NUM_MASTERS*ADDR_W  flattened; master i occupies slice [i*ADDR_W +: ADDR_W]. The same slicing applies to all flattened buses below.
- m_hwrite  in  NUM_MASTERS  per-master hwrite.
- m_hsize  in  NUM_MASTERS*3  per-master hsize.
- m_hburst  in  NUM_MASTERS*3  per-master hburst.
- m_hprot  in  NUM_MASTERS*4  per-master hprot.
- m_htrans  in  NUM_MASTERS*2  per-master htrans.
- m_hmastlock  in  NUM_MASTERS  per-master hmastlock.
- m_hwdata  in  NUM_MASTERS*DATA_W  per-master write data.
- m_hready  out  NUM_MASTERS  hready routed to the data-phase owner; 0 for all others.
- m_hresp  out  NUM_MASTERS  hresp routed to the data-phase owner; 0 for all others.
- m_hrdata  out  DATA_W  hrdata broadcast to all masters.
- ext_bus_req  in  1  external master requests the bus.
- ext_bus_ack  out  1  external master granted; all AHB outputs are driven idle.
- haddr  out  ADDR_W  AHB address.
- hwrite  out  1  AHB hwrite.
- hsize  out  3  AHB hsize.
- hburst  out  3  AHB hburst.
- hprot  out  4  AHB hprot.
- htrans  out  2  AHB htrans.
- hmastlock  out  1  AHB hmastlock.
- hwdata  out  DATA_W  AHB write data.
- hready  in  1  AHB hready.
- hresp  in  1  AHB hresp.
- hrdata  in  DATA_W  AHB read data.
- owner  out  4  current address-phase owner: 0..N-1 for an internal master; 4'hE for the external master; 4'hF for none.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, all m_bus_ack=0, ext_bus_ack=0, owner=4'hF.
  - data-phase valid=0, rr_ptr=0.
- States: IDLE, GRANT, EXT, DRAIN.
- IDLE: arbitration is combinational over the sampled requests; the grant is registered, so ack rises one cycle after req is sampled.
  - Priority 1: ext_bus_req (when EXT_EN=1) -> next state EXT.
  - Priority 2: internal requests -> next state GRANT.
    - RR_MODE=1: first requesting index at or after rr_ptr, searching cyclically; rr_ptr <= winner+1 mod NUM_MASTERS, wrapping from N-1 to 0.
    - RR_MODE=0: lowest requesting index wins; rr_ptr is unused.
  - No requests: stay IDLE.
- GRANT: owner holds the grant while its m_bus_req=1; there is no preemption, including while hmastlock=1.
  - When req is sampled 0: ack <= 0 and owner <= F at that edge.
  - Next state is DRAIN if a data phase is pending and hready=0, else IDLE.
- EXT: ext_bus_ack=1 while ext_bus_req=1. When req drops: ack <= 0 and next state IDLE.
- DRAIN: wait for hready=1, then IDLE.
- Minimum gap between consecutive grants is one IDLE cycle.
- Address-phase mux:
  - Driven from the owner's slices when owner is an internal index.
  - Otherwise outputs are idle: htrans=2'b00, haddr=0, hwrite=0, hsize=3'b011, hburst=0, hprot=4'b0011, hmastlock=0.
- Data phase:
  - dp_owner <= owner and dp_valid <= (htrans[1]==1) on every edge with hready=1; with hready=0 they hold.
  - hwdata is selected by dp_owner. hwdata=0 when dp_valid=0 or dp_owner is not an internal index.
  - m_hready and m_hresp are routed only to dp_owner.
- Simultaneous events:
  - Owner drops req while another master raises req in the same cycle: the new grant waits for IDLE.
  - ext_bus_req and an internal req arriving together in IDLE: ext wins.
- Error: hresp=1 is passed through unchanged. The arbiter does not release the grant on error; the master releases it.

Test Plan:
- Reset, then M1 req=1 at cycle 2 -> m_bus_ack=4'b0010 and owner=1 at cycle 3; haddr follows M1's haddr (e.g. 0x8000_0000).
- RR_MODE=1, M0..M3 req continuously, each dropping req after one NONSEQ -> grants in order 0,1,2,3,0; exactly one IDLE cycle between grants.
- RR_MODE=0, M2 and M1 req together -> M1 granted first; M2 granted after M1 releases.
- M0 write with hready=0 for 3 cycles in its data phase, M0 drops req, M3 req=1 -> state DRAIN; hwdata stays M0's (0xDEAD_BEEF) until hready=1; M3 ack follows, and m_hready[3] stays 0 during M0's data phase.
- ext_bus_req and M2 req in the same IDLE cycle -> ext_bus_ack=1 and htrans=00; after ext drops req, M2 is granted 2 cycles later.
- rst pulsed mid-burst of M1 -> all acks 0, owner=F, htrans=00 immediately; arbitration resumes after rst falls.
